instr_encoder: RTL
==================

# instr_encoder

Assembles RV32I instruction words from separate fields (opcode, funct3, funct7, rs1, rs2, rd, immediate, format) and writes them one after another into instruction memory through a write port. It is the inverse of the fetch-side field split: the field split turns a word into fields, and this block turns fields into a word. It sits between the test/boot program source and the instruction memory write port. Accepted words are stored at consecutive word addresses until the memory is full.

## Interface
Parameters:
- ADDR_W, 10: instruction memory word-address width.
- DEPTH, 1024: number of words that may be written; must satisfy DEPTH ≤ 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous restart: write address back to 0, pending word dropped.
- in_valid  input  1  field tuple valid.
- in_ready  output  1  block accepts the tuple this cycle.
- fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  input  7  opcode field.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field.
- rs1, rs2, rd  input  5 each  register indices.
- imm  input  32  immediate; byte offset for B/J, full 32-bit value for U.
- imem_we  output  1  write request.
- imem_ready  input  1  memory accepts the write this cycle.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- full  output  1  DEPTH words written.
- err  output  1  one-cycle pulse on accepting an illegal fmt.
- count  output  ADDR_W+1  number of completed writes.

## Operation
- Encoding (bit fields listed MSB first):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
- Fields and immediate bits not used by a format are ignored.
- The encoder does not check imm range or alignment; out-of-range bits are truncated.
- The encoder does not check opcode/format consistency.
- Illegal fmt: the tuple is accepted (handshake completes), err pulses the next cycle, and nothing is written.
- States:
  - IDLE: no pending word.
  - BUSY: output register holds a word; imem_we=1.
  - FULL: address reached DEPTH.
- Transitions:
  - IDLE→BUSY on a legal accept.
  - BUSY→IDLE when the write completes (imem_we && imem_ready) and no new accept occurs that cycle.
  - BUSY→BUSY when a write completes and a new word is accepted in the same cycle.
  - BUSY→FULL when the write to address DEPTH-1 completes.
  - Any state →IDLE on clear.
- in_ready = (state==IDLE || (state==BUSY && imem_ready && imem_addr!=DEPTH-1)) && !clear.
- Address increments by 1 on each completed write. It never wraps; FULL blocks further input until clear.
- clear wins over every simultaneous event. A write completing in the same cycle still reaches memory, but count and address reset to 0.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after it; imem_we=0, imem_addr=0, imem_wdata=0, full=0, err=0, count=0; state IDLE.
- Latency: a tuple accepted at edge N gives imem_we=1 with valid addr/data from cycle N+1.
- Sustained throughput is 1 word/cycle while imem_ready=1.
- While imem_we=1 and imem_ready=0, imem_addr and imem_wdata hold stable and in_ready=0.
- full rises the cycle after the final write completes and stays high until clear or reset.
- err is registered and lasts exactly one cycle per illegal accept.
- Reset mid-write: the pending word is lost and no write completes.

## Structure
- Shared package rv32i_pkg holds:
  - the fmt_e enum (R, I, S, B, U, J);
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - the encoder state enum.
- Natural sub-module: imm_packer, purely combinational, mapping (fmt, fields, imm) to a 32-bit word plus an illegal flag. The top level holds the handshake, output register, address counter and FSM.

## Test plan
- R add x3,x1,x2 (opcode 0x33, funct3 0, funct7 0) with imem_ready=1 → imem_wdata=0x002081B3 at addr 0 one cycle after accept; count=1.
- I addi x1,x0,5 then S sw x2,8(x1) back-to-back → 0x00500093 at addr 0, 0x0020A423 at addr 1 on consecutive cycles.
- B beq x0,x0,imm=-4 → 0xFE000EE3; U lui x5,imm=0x12345000 → 0x123452B7; J jal x0,0 → 0x0000006F.
- Hold imem_ready=0 for 3 cycles with in_valid=1 → in_ready=0, imem_addr/imem_wdata stable, no second accept; the write completes on release.
- fmt=6 → err pulses once, no imem_we, count unchanged; then DEPTH legal writes → full=1, in_ready=0; clear → addr 0, count 0, full 0.
- clear and reset asserted while BUSY → imem_we=0 the next cycle and all outputs at their reset values.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes and the
// encoder's state encoding.
package rv32i_pkg;

  // Instruction formats as presented on the fmt input (6 and 7 are illegal)
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // RV32I base opcodes
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  // Encoder write-side state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input handshake plus instruction-memory write port.
// master = program source / memory side, slave = the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              full;
  logic              err;
  logic [ADDR_W:0]   count;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, imm, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, full, err, count
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, imm, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, full, err, count
  );
endinterface

// File: rtl/instr_encoder_imm_packer.sv
// Purely combinational packing of RV32I fields into a 32-bit word.
// Unused fields/immediate bits are simply not selected; no range checks.
module imm_packer
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the bit layout for the requested format
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field tuples into RV32I words and writes them to consecutive
// instruction-memory addresses until DEPTH words have been written.
// The bus interface must be instantiated with the same ADDR_W.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input logic            clk,
  input logic            rst_n,
  input logic            clear,
  instr_encoder_if.slave bus
);

  // The address register doubles as the completed-write count
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  enc_state_e      state_reg, state_next;
  logic [ADDR_W:0] count_reg, count_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic            err_reg, err_next;

  logic [31:0] packed_word;
  logic        packed_illegal;
  logic        in_ready_int;
  logic        accept;
  logic        write_done;

  imm_packer u_packer (
    .fmt     (bus.fmt),
    .opcode  (bus.opcode),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .rd      (bus.rd),
    .imm     (bus.imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // Handshake: accept when idle, or when the pending write retires this
  // cycle and it is not the last slot; never during reset or clear
  always_comb begin
    in_ready_int = rst_n && !clear &&
                   ((state_reg == ST_IDLE) ||
                    ((state_reg == ST_BUSY) && bus.imem_ready && (count_reg != LAST_ADDR)));
    accept       = bus.in_valid && in_ready_int;
    write_done   = (state_reg == ST_BUSY) && bus.imem_ready;
  end

  // Next-state, address counter, output word and error pulse; clear overrides all
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wdata_next = wdata_reg;
    err_next   = 1'b0;
    if (write_done) count_next = count_reg + 1'b1;
    if (accept && !packed_illegal) wdata_next = packed_word;
    if (accept && packed_illegal) err_next = 1'b1;
    case (state_reg)
      ST_IDLE: if (accept && !packed_illegal) state_next = ST_BUSY;
      ST_BUSY: begin
        if (write_done) begin
          if (count_reg == LAST_ADDR)          state_next = ST_FULL;
          else if (accept && !packed_illegal)  state_next = ST_BUSY;
          else                                 state_next = ST_IDLE;
        end
      end
      ST_FULL: state_next = ST_FULL;
      default: state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next = ST_IDLE;
      count_next = '0;
      wdata_next = 32'd0;
      err_next   = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      wdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.imem_we    = (state_reg == ST_BUSY);
  assign bus.imem_addr  = count_reg[ADDR_W-1:0];
  assign bus.imem_wdata = wdata_reg;
  assign bus.full       = (state_reg == ST_FULL);
  assign bus.err        = err_reg;
  assign bus.count      = count_reg;

endmodule
